kogge_stone_addsub_pipe: RTL



---
 rtl/kogge_stone_addsub_pipe_pkg.sv | 29 ++
 rtl/kogge_stone_addsub_pipe_black_cell.sv | 35 +++
 rtl/kogge_stone_addsub_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/kogge_stone_addsub_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : ks_pkg                                                      |
// | Purpose    : Shared types and helpers for the pipelined Kogge-Stone      |
// |              adder/subtractor (prefix column type, op encoding, level    |
// |              count helper).                                              |
// | Ports      : none                                                        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package ks_pkg;

  // One prefix column: group generate / group propagate.
  typedef struct packed {
    logic g;
    logic p;
  } ks_gp_t;

  typedef enum logic {
    KS_ADD = 1'b0,
    KS_SUB = 1'b1
  } ks_op_e;

  // Number of prefix levels needed to span an n-bit operand.
  function automatic int ks_levels(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kogge_stone_addsub_pipe_black_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : ks_black_cell                                               |
// | Purpose    : Kogge-Stone prefix operator. Merges a higher-order (G,P)    |
// |              group with the adjacent lower-order group.                  |
// | Ports      : g_hi_i/p_hi_i  - upper group generate/propagate            |
// |              g_lo_i/p_lo_i  - lower group generate/propagate            |
// |              g_o/p_o        - merged group generate/propagate           |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module ks_black_cell
  import ks_pkg::*;
(
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);

  ks_gp_t hi;
  ks_gp_t lo;
  ks_gp_t res;

  assign hi    = '{g: g_hi_i, p: p_hi_i};
  assign lo    = '{g: g_lo_i, p: p_lo_i};
  assign res.g = hi.g | (hi.p & lo.g);
  assign res.p = hi.p & lo.p;

  assign g_o = res.g;
  assign p_o = res.p;

endmodule
`default_nettype wire

// File: rtl/kogge_stone_addsub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : kogge_stone_addsub_pipe                                     |
// | Purpose    : N-bit fully pipelined Kogge-Stone adder/subtractor with a   |
// |              valid/ready stream interface. One register stage per        |
// |              prefix level; latency L+2 cycles, one beat per clock.       |
// | Ports      : clk, rst_n      - clock, synchronous active-low reset       |
// |              in_valid_i/in_ready_o   - operand handshake                 |
// |              a_i, b_i        - operands                                  |
// |              sub_i, cin_i    - 0: a+b+cin, 1: a-b-cin (cin = borrow-in)  |
// |              out_valid_o/out_ready_i - result handshake                  |
// |              sum_o, cout_o, ovf_o, zero_o - result and flags             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module kogge_stone_addsub_pipe
  import ks_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  input  logic         cin_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o,
  output logic         zero_o
);

  localparam int L = ks_levels(N);

  // ---------------------------------------------------------------------------
  // Handshake: the whole pipe moves together or holds together.
  // ---------------------------------------------------------------------------
  logic advance;
  logic accept;

  // ---------------------------------------------------------------------------
  // Operand preparation
  // ---------------------------------------------------------------------------
  ks_op_e       op;
  logic [N-1:0] b_eff;
  logic         c0;
  logic [N-1:0] g_bit;
  logic [N-1:0] p_bit;

  assign op    = ks_op_e'(sub_i);
  assign b_eff = (op == KS_SUB) ? ~b_i : b_i;
  assign c0    = cin_i ^ sub_i;
  assign g_bit = a_i & b_eff;
  assign p_bit = a_i ^ b_eff;

  // ---------------------------------------------------------------------------
  // Pipeline state. Index 0 is the operand stage, index k the output of
  // prefix level k. pb_* carries the bitwise propagate for the final sum.
  // ---------------------------------------------------------------------------
  wire  [L:0][N-1:0] g_d;
  wire  [L:0][N-1:0] p_d;
  logic [L:0][N-1:0] g_q;
  logic [L:0][N-1:0] p_q;
  logic [L:0][N-1:0] pb_d;
  logic [L:0][N-1:0] pb_q;
  logic [L:0]        c0_d;
  logic [L:0]        c0_q;
  logic [L:0]        v_d;
  logic [L:0]        v_q;

  // The carry-in column (bit -1: g=c0, p=0) is merged into bit 0 before the
  // tree. Bit 0 then carries a zero propagate, so every column's group that
  // reaches bit 0 already includes c0 and the tree only spans bits 0..N-1.
  ks_black_cell u_fold (
    .g_hi_i (g_bit[0]),
    .p_hi_i (p_bit[0]),
    .g_lo_i (c0),
    .p_lo_i (1'b0),
    .g_o    (g_d[0][0]),
    .p_o    (p_d[0][0])
  );

  assign g_d[0][N-1:1] = g_bit[N-1:1];
  assign p_d[0][N-1:1] = p_bit[N-1:1];

  // Prefix levels: level k merges each column with the one 2^(k-1) below it.
  for (genvar k = 1; k <= L; k++) begin : g_level
    localparam int S = 1 << (k - 1);
    for (genvar i = 0; i < N; i++) begin : g_col
      if (i >= S) begin : g_black
        ks_black_cell u_cell (
          .g_hi_i (g_q[k-1][i]),
          .p_hi_i (p_q[k-1][i]),
          .g_lo_i (g_q[k-1][i-S]),
          .p_lo_i (p_q[k-1][i-S]),
          .g_o    (g_d[k][i]),
          .p_o    (p_d[k][i])
        );
      end else begin : g_pass
        assign g_d[k][i] = g_q[k-1][i];
        assign p_d[k][i] = p_q[k-1][i];
      end
    end
  end

  assign pb_d = {pb_q[L-1:0], p_bit};
  assign c0_d = {c0_q[L-1:0], c0};
  assign v_d  = {v_q[L-1:0], accept};

  // ---------------------------------------------------------------------------
  // Final stage: after level L, g_q[L][i] is the carry out of bit i.
  // ---------------------------------------------------------------------------
  logic [N-1:0] carry_in;
  logic [N-1:0] sum_d;
  logic         cout_d;
  logic         ovf_d;
  logic         zero_d;

  assign carry_in = {g_q[L][N-2:0], c0_q[L]};
  assign sum_d    = pb_q[L] ^ carry_in;
  assign cout_d   = g_q[L][N-1];
  assign ovf_d    = g_q[L][N-1] ^ g_q[L][N-2];
  assign zero_d   = ~|sum_d;

  // The group propagate of the last level has no consumer.
  logic unused_p_last;
  assign unused_p_last = ^p_q[L];

  logic         out_valid_q;
  logic [N-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;
  logic         zero_q;

  assign advance = ~out_valid_q | out_ready_i;
  assign accept  = in_valid_i & advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q         <= '0;
      p_q         <= '0;
      pb_q        <= '0;
      c0_q        <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      g_q         <= g_d;
      p_q         <= p_d;
      pb_q        <= pb_d;
      c0_q        <= c0_d;
      v_q         <= v_d;
      out_valid_q <= v_q[L];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready_o  = advance;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule
`default_nettype wire
